vga_sync_gen: RTL and testbench

//   Upstream timing stage of the BlockyRoads renderer. Divides the system clock into a pixel-rate

---
 rtl/vga_sync_gen_pkg.sv | 35 +++
 rtl/vga_sync_gen_pix_tick_div.sv | 32 +++
 rtl/vga_sync_gen.sv | 121 ++++++++++++
 tb/tb_vga_sync_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// VGA 640x480@60 timing constants, counter type and decode helpers shared by the sync generator and its users.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_sync_gen_pkg;

    // Counter width covers totals up to 1024 pixels or lines.
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    // Default 640x480@60 timing with a 100 MHz system clock.
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Decoded per-pixel sync state, registered together so the three bits stay aligned.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// Pixel-rate enable: divides clk by CLK_DIV, tick high for one clk every CLK_DIV clks.
// Latency: tick first rises CLK_DIV-1 clks after clr is released.
// Backpressure: none; free-running.
//   clk  : system clock
//   clr  : synchronous active-high reset, restarts the divide cycle at 0
//   tick : one-clk enable, high when the divider sits on its last count
module pix_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel enable, x/y counters, registered hsync/vsync/video_on and line/frame strobes.
// Latency: decode registered from next-state counters, so all outputs are cycle-aligned with x/y (zero lag).
// Backpressure: none; free-running timing master.
//   clk, clr            : system clock, synchronous active-high reset
//   pix_tick            : one-clk pixel enable
//   hsync, vsync        : sync pulses at SYNC_POL level
//   video_on            : inside the visible 640x480 window
//   x, y                : raw counters (gate with video_on)
//   line_start          : one-clk strobe on the first clk of x == 0
//   frame_start         : one-clk strobe on the first clk of (x,y) == (0,0)
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_LO   = cnt_t'(HS_START);
    localparam cnt_t HS_HI   = cnt_t'(HS_END);
    localparam cnt_t VS_LO   = cnt_t'(VS_START);
    localparam cnt_t VS_HI   = cnt_t'(VS_END);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be at least 2");
        end
        if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
        end
    endgenerate

    logic  tick;
    logic  x_wrap;
    logic  y_wrap;
    cnt_t  x_nxt;
    cnt_t  y_nxt;
    sync_t sync_nxt;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    assign pix_tick = tick;

    // Next-state counters; the sync decode below looks at these rather than
    // the current x/y so the registered outputs land on the same edge.
    always_comb begin
        x_wrap = (x == H_LAST);
        y_wrap = (y == V_LAST);
        x_nxt  = x;
        y_nxt  = y;
        if (tick) begin
            if (x_wrap) begin
                x_nxt = '0;
                y_nxt = y_wrap ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
        end
        sync_nxt.hsync    = in_window(x_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
        sync_nxt.vsync    = in_window(y_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
        sync_nxt.video_on = (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
    end

    // Reset parks the counters on the last pixel of a frame so the first
    // tick after release starts a clean frame with both strobes.
    always_ff @(posedge clk) begin
        if (clr) begin
            x           <= H_LAST;
            y           <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= sync_nxt.hsync;
            vsync       <= sync_nxt.vsync;
            video_on    <= sync_nxt.video_on;
            line_start  <= tick && x_wrap;
            frame_start <= tick && x_wrap && y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 build plus a small-geometry active-high CLK_DIV=2 build.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_a = 1'b0;
    logic clr_b = 1'b0;

    logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0] b_x, b_y;

    vga_sync_gen dut_a (
        .clk(clk), .clr(clr_a), .pix_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    // Small frame: H 8+2+3+2 = 15 (sync 10..12), V 6+1+2+2 = 11 (sync 7..8).
    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .clr(clr_b), .pix_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    typedef struct packed {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        bit pol;
    } geom_t;

    typedef struct {
        bit   dut;   // 0 = default build, 1 = small build
        int   n;     // clk cycle index after clr release
        obs_t exp;
    } vec_t;

    localparam geom_t GA = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    localparam geom_t GB = '{2, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1};

    obs_t obs_a, obs_b;
    assign obs_a = {a_tick, a_hs, a_vs, a_von, a_x, a_y, a_ls, a_fs};
    assign obs_b = {b_tick, b_hs, b_vs, b_von, b_x, b_y, b_ls, b_fs};

    int tests = 0;
    int fails = 0;

    function automatic string fmt(obs_t o);
        return $sformatf("tick=%0b hs=%0b vs=%0b von=%0b x=%0d y=%0d ls=%0b fs=%0b",
                         o.tick, o.hs, o.vs, o.von, o.x, o.y, o.ls, o.fs);
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Closed-form reference: n clks after release, n/d ticks have happened;
    // tick t >= 1 lands on raster position t-1 counted from (0,0).
    function automatic obs_t model(geom_t g, int n);
        int   ht, vt, t, p, xx, yy;
        obs_t o;
        ht = g.ha + g.hfp + g.hsw + g.hbp;
        vt = g.va + g.vfp + g.vsw + g.vbp;
        t  = n / g.d;
        if (t == 0) begin
            xx = ht - 1;
            yy = vt - 1;
        end else begin
            p  = (t - 1) % (ht * vt);
            xx = p % ht;
            yy = p / ht;
        end
        o.tick = ((n % g.d) == g.d - 1);
        o.x    = 10'(xx);
        o.y    = 10'(yy);
        o.von  = (xx < g.ha) && (yy < g.va);
        o.hs   = (xx >= g.ha + g.hfp && xx < g.ha + g.hfp + g.hsw) ? g.pol : !g.pol;
        o.vs   = (yy >= g.va + g.vfp && yy < g.va + g.vfp + g.vsw) ? g.pol : !g.pol;
        o.ls   = (t >= 1) && ((n % g.d) == 0) && (xx == 0);
        o.fs   = o.ls && (yy == 0);
        return o;
    endfunction

    // Scoreboard: expectation pushed as each edge's inputs are applied,
    // popped and compared on the following falling edge.
    int   n_a = 0, n_b = 0;
    bit   arm_a = 0, arm_b = 0;
    obs_t q_a[$], q_b[$];

    always @(posedge clk) begin
        if (clr_a) begin n_a = 0; arm_a = 1; end else n_a = n_a + 1;
        if (clr_b) begin n_b = 0; arm_b = 1; end else n_b = n_b + 1;
        if (arm_a) q_a.push_back(model(GA, n_a));
        if (arm_b) q_b.push_back(model(GB, n_b));
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) check_obs($sformatf("sb_a n=%0d", n_a), obs_a, q_a.pop_front());
        if (q_b.size() > 0) check_obs($sformatf("sb_b n=%0d", n_b), obs_b, q_b.pop_front());
    end

    // Window statistics over the first line (A) and two frames (B).
    int cyc = 0;
    bit cnt_en = 0;
    int von_a = 0, hs_a = 0, ls_cnt_a = 0, ls1_a = 0, ls2_a = 0;
    int von_b = 0, vs_b = 0, fs_cnt_b = 0, fs1_b = 0, fs2_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (cnt_en) begin
            if (a_tick && a_y == 10'd0 && a_von) von_a++;
            if (a_tick && a_y == 10'd0 && !a_hs) hs_a++;
            if (a_ls) begin
                ls_cnt_a++;
                if (ls_cnt_a == 1) ls1_a = cyc;
                if (ls_cnt_a == 2) ls2_a = cyc;
            end
            if (b_fs) begin
                fs_cnt_b++;
                if (fs_cnt_b == 1) fs1_b = cyc;
                if (fs_cnt_b == 2) fs2_b = cyc;
            end
            if (b_tick && (fs_cnt_b == 1 || fs_cnt_b == 2)) begin
                if (b_von) von_b++;
                if (b_vs) vs_b++;
            end
        end
    end

    function automatic vec_t mk(bit dut, int n, bit tk, bit hs, bit vs, bit von,
                                int xx, int yy, bit ls, bit fs);
        vec_t v;
        v.dut = dut;
        v.n   = n;
        v.exp = {tk, hs, vs, von, 10'(xx), 10'(yy), ls, fs};
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int guard;

        // Hand-derived vectors, ascending in n. Fields: tick hs vs von x y ls fs.
        vecs.push_back(mk(1,    0, 0,0,0,0,  14, 10, 0,0));
        vecs.push_back(mk(0,    0, 0,1,1,0, 799,524, 0,0));
        vecs.push_back(mk(1,    1, 1,0,0,0,  14, 10, 0,0));
        vecs.push_back(mk(1,    2, 0,0,0,1,   0,  0, 1,1));
        vecs.push_back(mk(0,    3, 1,1,1,0, 799,524, 0,0));
        vecs.push_back(mk(1,    3, 1,0,0,1,   0,  0, 0,0));
        vecs.push_back(mk(0,    4, 0,1,1,1,   0,  0, 1,1));
        vecs.push_back(mk(0,    5, 0,1,1,1,   0,  0, 0,0));
        vecs.push_back(mk(0,    8, 0,1,1,1,   1,  0, 0,0));
        vecs.push_back(mk(1,   16, 0,0,0,1,   7,  0, 0,0));
        vecs.push_back(mk(1,   22, 0,1,0,0,  10,  0, 0,0));
        vecs.push_back(mk(1,  120, 0,0,0,0,  14,  3, 0,0));
        vecs.push_back(mk(1,  122, 0,0,0,1,   0,  4, 1,0));
        vecs.push_back(mk(1,  212, 0,0,1,0,   0,  7, 1,0));
        vecs.push_back(mk(1,  266, 0,1,1,0,  12,  8, 0,0));
        vecs.push_back(mk(1,  272, 0,0,0,0,   0,  9, 1,0));
        vecs.push_back(mk(1,  330, 0,0,0,0,  14, 10, 0,0));
        vecs.push_back(mk(1,  332, 0,0,0,1,   0,  0, 1,1));
        vecs.push_back(mk(0, 2560, 0,1,1,1, 639,  0, 0,0));
        vecs.push_back(mk(0, 2564, 0,1,1,0, 640,  0, 0,0));
        vecs.push_back(mk(0, 2624, 0,1,1,0, 655,  0, 0,0));
        vecs.push_back(mk(0, 2628, 0,0,1,0, 656,  0, 0,0));
        vecs.push_back(mk(0, 3008, 0,0,1,0, 751,  0, 0,0));
        vecs.push_back(mk(0, 3012, 0,1,1,0, 752,  0, 0,0));
        vecs.push_back(mk(0, 3203, 1,1,1,0, 799,  0, 0,0));
        vecs.push_back(mk(0, 3204, 0,1,1,1,   0,  1, 1,0));
        vecs.push_back(mk(0, 3205, 0,1,1,1,   0,  1, 0,0));

        // Reset both builds together, then release.
        @(negedge clk);
        clr_a = 1'b1;
        clr_b = 1'b1;
        repeat (3) @(negedge clk);
        clr_a  = 1'b0;
        clr_b  = 1'b0;
        cnt_en = 1'b1;

        foreach (vecs[i]) begin
            guard = 0;
            while (n_a != vecs[i].n && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 5000) timeout($sformatf("vec%0d", i));
            else if (vecs[i].dut) check_obs($sformatf("vec%0d_b n=%0d", i, vecs[i].n), obs_b, vecs[i].exp);
            else                  check_obs($sformatf("vec%0d_a n=%0d", i, vecs[i].n), obs_a, vecs[i].exp);
        end
        cnt_en = 1'b0;

        check_int("a_video_ticks_line0", von_a, 640);
        check_int("a_hsync_ticks_line0", hs_a, 96);
        check_int("a_line_period", ls2_a - ls1_a, 3200);
        check_int("b_video_ticks_2frames", von_b, 96);
        check_int("b_vsync_ticks_2frames", vs_b, 60);
        check_int("b_frame_period", fs2_b - fs1_b, 330);

        // Mid-frame clr on B while inside hsync.
        guard = 0;
        while (!(b_x == 10'd11 && b_y == 10'd5) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) timeout("b_reach_mid");
        else begin
            check_int("b_mid_in_hsync", int'(b_hs), 1);
            clr_b = 1'b1;
            @(negedge clk);
            clr_b = 1'b0;
            check_obs("b_midclr_reset", obs_b, {1'b0,1'b0,1'b0,1'b0,10'd14,10'd10,1'b0,1'b0});
            repeat (2) @(negedge clk);
            check_obs("b_midclr_resume", obs_b, {1'b0,1'b0,1'b0,1'b1,10'd0,10'd0,1'b1,1'b1});
        end

        // Mid-frame clr on A while inside hsync.
        guard = 0;
        while (!(a_x == 10'd700 && a_y == 10'd1) && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8000) timeout("a_reach_mid");
        else begin
            check_int("a_mid_in_hsync", int'(a_hs), 0);
            clr_a = 1'b1;
            @(negedge clk);
            clr_a = 1'b0;
            check_obs("a_midclr_reset", obs_a, {1'b0,1'b1,1'b1,1'b0,10'd799,10'd524,1'b0,1'b0});
            repeat (3) @(negedge clk);
            check_int("a_midclr_first_tick", int'(a_tick), 1);
            @(negedge clk);
            check_obs("a_midclr_resume", obs_a, {1'b0,1'b1,1'b1,1'b1,10'd0,10'd0,1'b1,1'b1});
        end

        repeat (200) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
